// File: rtl/atualiza_linha_fifo_if.sv
// Bus between the line-refresh FIFO and its user: push/pop handshake,
// current time stamp, and the raw and refreshed head line.
`timescale 1ns/1ps
interface atualiza_linha_fifo_if #(
    parameter int unsigned DATA_WIDTH = 72,
    parameter int unsigned BW         = 4,
    parameter int unsigned LW         = 12
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic [BW-1:0]         cur_bucket;
    logic [LW-1:0]         cur_loop;
    logic [DATA_WIDTH-1:0] raw_dout;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  nearly_full;
    logic                  empty;
    logic                  err;

    modport master (
        output din, wr_en, rd_en, cur_bucket, cur_loop,
        input  raw_dout, dout, full, nearly_full, empty, err
    );

    modport slave (
        input  din, wr_en, rd_en, cur_bucket, cur_loop,
        output raw_dout, dout, full, nearly_full, empty, err
    );
endinterface

// File: rtl/atualiza_linha_fifo.sv
// Fall-through FIFO of SRAM lines whose head is presented both raw and
// with its Bloom time buckets aged against the current {loop, bucket}.
// Optional sticky protocol-error flag: ATUALIZA_LINHA_FIFO_ERR_CHECK_EN.
`timescale 1ns/1ps
module atualiza_linha_fifo #(
    parameter int unsigned DATA_WIDTH     = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3,
    parameter int unsigned BUCKET_SZ      = 4,
    parameter int unsigned BLOOM_INIT_POS = 16
) (
    input logic                  clk,
    input logic                  reset,
    atualiza_linha_fifo_if.slave fifo
);
    localparam int unsigned NUM_BUCKETS = (DATA_WIDTH - BLOOM_INIT_POS) / BUCKET_SZ;
    localparam int unsigned BW          = $clog2(NUM_BUCKETS);
    localparam int unsigned LW          = BLOOM_INIT_POS - BW;
    localparam int unsigned DEPTH       = 1 << MAX_DEPTH_BITS;
    localparam int unsigned CW          = MAX_DEPTH_BITS + 1;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic                      full_q;
    logic                      nearly_full_q;
    logic                      empty_q;
    logic                      push;
    logic                      pop;
    logic [DATA_WIDTH-1:0]     head;
    logic [DATA_WIDTH-1:0]     line;

    logic [BW-1:0]             s_bucket;
    logic [LW-1:0]             s_loop;
    logic [LW-1:0]             s_loop_inc;
    logic                      same_loop;
    logic                      next_loop;
    logic                      clr;

    // Acceptance uses the registered flags seen before the edge.
    assign push = fifo.wr_en && !full_q;
    assign pop  = fifo.rd_en && !empty_q;

    // Occupancy after this cycle's accepted operations.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count and flags; flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            nearly_full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            count         <= count_next;
            empty_q       <= (count_next == '0);
            full_q        <= (count_next == CW'(DEPTH));
            nearly_full_q <= (count_next >= CW'(DEPTH - 1));
        end
    end

    // Line storage; contents survive reset, the reset cycle never writes.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= fifo.din;
    end

    assign head          = mem[rd_ptr];
    assign fifo.raw_dout = head;
    assign fifo.full        = full_q;
    assign fifo.nearly_full = nearly_full_q;
    assign fifo.empty       = empty_q;

    assign s_bucket   = head[BW-1:0];
    assign s_loop     = head[BLOOM_INIT_POS-1:BW];
    assign s_loop_inc = s_loop + LW'(1);
    assign same_loop  = (fifo.cur_loop == s_loop)     && (fifo.cur_bucket >= s_bucket);
    assign next_loop  = (fifo.cur_loop == s_loop_inc) && (fifo.cur_bucket <  s_bucket);

    // Age the head: clear every bucket whose time slot has elapsed since the
    // stored stamp; a stamp more than one loop old (or in the future) clears all.
    always_comb begin
        line = head;
        clr  = 1'b0;
        for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
            if (same_loop) begin
                clr = (i > 32'(s_bucket)) && (i <= 32'(fifo.cur_bucket));
            end else if (next_loop) begin
                clr = (i > 32'(s_bucket)) || (i <= 32'(fifo.cur_bucket));
            end else begin
                clr = 1'b1;
            end
            if (clr) line[BLOOM_INIT_POS + BUCKET_SZ*i +: BUCKET_SZ] = '0;
        end
        line[BLOOM_INIT_POS-1:0] = {fifo.cur_loop, fifo.cur_bucket};
    end

    assign fifo.dout = line;

`ifdef ATUALIZA_LINHA_FIFO_ERR_CHECK_EN
    logic err_q;

    // Sticky flag for a write while full or a read while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((fifo.wr_en && full_q) || (fifo.rd_en && empty_q)) begin
            err_q <= 1'b1;
        end
    end

    assign fifo.err = err_q;
`else
    assign fifo.err = 1'b0;
`endif
endmodule

// File: tb/tb_atualiza_linha_fifo.sv
// Randomized bench for atualiza_linha_fifo against a queue model with an
// elapsed-slot description of bucket aging.
`timescale 1ns/1ps
module tb_atualiza_linha_fifo;
    localparam int DW = 72;
    localparam int NB = 14;
    localparam int BP = 16;
    localparam int BS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] q[$];
    logic          err_exp = 1'b0;
    logic [11:0]   gl = 12'd0;

    atualiza_linha_fifo_if #(.DATA_WIDTH(72), .BW(4), .LW(12)) bus();

    atualiza_linha_fifo #(
        .DATA_WIDTH(72),
        .MAX_DEPTH_BITS(3),
        .BUCKET_SZ(4),
        .BLOOM_INIT_POS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Buckets elapsed since the stamp are cleared, walking forward from the
    // stored slot with wrap over NB slots; anything not 0/1 loop behind clears all.
    function automatic logic [DW-1:0] refresh(input logic [DW-1:0] ln, input logic [11:0] cl, input logic [3:0] cb);
        logic [DW-1:0] r;
        logic [11:0]   sl;
        logic [11:0]   diff;
        int            sb;
        int            c;
        int            elapsed;
        r    = ln;
        sl   = ln[15:4];
        sb   = int'(ln[3:0]);
        c    = int'(cb);
        diff = cl - sl;
        if (diff == 12'd0 && c >= sb)      elapsed = c - sb;
        else if (diff == 12'd1 && c < sb)  elapsed = c + NB - sb;
        else                               elapsed = NB;
        for (int k = 1; k <= elapsed; k++) r[BP + BS*((sb + k) % NB) +: BS] = 4'h0;
        r[15:0] = {cl, cb};
        return r;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [11:0] l, input logic [3:0] b, input logic [13:0] zm);
        logic [DW-1:0] r;
        r = '0;
        r[15:0] = {l, b};
        for (int k = 0; k < NB; k++) r[BP + BS*k +: BS] = zm[k] ? 4'h0 : 4'hF;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_line(input logic [11:0] base);
        logic [DW-1:0] r;
        logic [11:0]   sl;
        r[31:0]  = $urandom;
        r[63:32] = $urandom;
        r[71:64] = 8'($urandom);
        case ($urandom_range(0, 4))
            0:       sl = base;
            1:       sl = base - 12'd1;
            2:       sl = base - 12'd2;
            3:       sl = base + 12'd1;
            default: sl = 12'($urandom);
        endcase
        r[15:4] = sl;
        r[3:0]  = 4'($urandom_range(0, 13));
        return r;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit push_ok;
        bit pop_ok;
        bit err_set;
        err_set = 1'b0;
        @(negedge clk);
        check("empty", bus.empty, q.size() == 0);
        check("full", bus.full, q.size() == 8);
        check("nearly_full", bus.nearly_full, q.size() >= 7);
        check("err", bus.err, err_exp);
        if (q.size() > 0) begin
            check("raw_dout", bus.raw_dout, q[0]);
            check("dout", bus.dout, refresh(q[0], bus.cur_loop, bus.cur_bucket));
        end
        push_ok = bus.wr_en && q.size() < 8;
        pop_ok  = bus.rd_en && q.size() > 0;
`ifdef ATUALIZA_LINHA_FIFO_ERR_CHECK_EN
        if ((bus.wr_en && q.size() == 8) || (bus.rd_en && q.size() == 0)) err_set = 1'b1;
`endif
        @(posedge clk);
        if (pop_ok)  q.delete(0);
        if (push_ok) q.push_back(bus.din);
        if (err_set) err_exp = 1'b1;
        #1;
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        reset      = 1'b1;
        bus.wr_en  = wr;
        bus.rd_en  = rd;
        bus.din    = rand_line(gl);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        q.delete();
        err_exp    = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [11:0] sl, input logic [3:0] sb,
                            input logic [11:0] cl, input logic [3:0] cb, input logic [13:0] zm);
        bus.din   = mk(sl, sb, 14'h0);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        cycle();
        bus.wr_en      = 1'b0;
        bus.cur_loop   = cl;
        bus.cur_bucket = cb;
        #2;
        check(tag, bus.dout, mk(cl, cb, zm));
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.din        = '0;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.cur_loop   = '0;
        bus.cur_bucket = '0;
        do_reset(1'b0, 1'b0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_nf", bus.nearly_full, 1'b0);
        cycle();

        directed("req22_fwd",   12'd5,    4'd3,  12'd5, 4'd6, 14'b00_0000_0111_0000);
        directed("req23_wrap",  12'd5,    4'd12, 12'd6, 4'd1, 14'b10_0000_0000_0011);
        directed("req23_old",   12'd3,    4'd0,  12'd5, 4'd0, 14'h3FFF);
        directed("req24_lwrap", 12'd4095, 4'd13, 12'd0, 4'd0, 14'h0001);
        directed("same_stamp",  12'd7,    4'd9,  12'd7, 4'd9, 14'h0000);
        directed("future",      12'd8,    4'd2,  12'd7, 4'd9, 14'h3FFF);

        bus.cur_loop   = gl;
        bus.cur_bucket = 4'd5;
        for (int i = 0; i < 9; i++) begin
            bus.din   = rand_line(gl);
            bus.wr_en = 1'b1;
            cycle();
            if (i == 6) begin
                check("nf_at7", bus.nearly_full, 1'b1);
                check("full_at7", bus.full, 1'b0);
            end
            if (i >= 7) check("full_at8", bus.full, 1'b1);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        bus.rd_en = 1'b0;
        check("drained_empty", bus.empty, 1'b1);
        cycle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) gl = gl + 12'd1;
            bus.cur_loop   = gl;
            bus.cur_bucket = 4'($urandom_range(0, 13));
            bus.wr_en      = ($urandom_range(0, 99) < 55);
            bus.rd_en      = ($urandom_range(0, 99) < 45);
            bus.din        = rand_line(gl);
            cycle();
        end

        do_reset(1'b0, 1'b0);
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din = rand_line(gl);
            cycle();
        end
        check("three_not_empty", bus.empty, 1'b0);
        do_reset(1'b1, 1'b1);
        check("rst_mid_empty", bus.empty, 1'b1);
        check("rst_mid_nf", bus.nearly_full, 1'b0);
        cycle();

`ifdef ATUALIZA_LINHA_FIFO_ERR_CHECK_EN
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        check("err_set", bus.err, 1'b1);
        repeat (3) cycle();
        check("err_sticky", bus.err, 1'b1);
        do_reset(1'b0, 1'b0);
        check("err_clear", bus.err, 1'b0);
        cycle();
`else
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        check("err_tied", bus.err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
